// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between port A (CPU) and
// port B (debug/DMA loader). Zeroes the memory after reset, then serves the
// two ports with round-robin arbitration and registered, 1-cycle read data.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | post-reset sweep, writes zero to word clr_cnt each cycle
// ST_SERVE | normal operation, one combinational grant per cycle

module dmem_arbiter #(
    parameter int DW             = 32,
    parameter int DEPTH          = 64,
    parameter int CW             = 6,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [31:0]   a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [31:0]   b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic          mem_read,
    output logic          mem_write,
    output logic [31:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          init_busy,
    output logic          addr_err
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    state_t        state_q, state_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic          last_gnt_q, last_gnt_d;
    logic          a_rvalid_q, a_rvalid_d;
    logic          b_rvalid_q, b_rvalid_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          addr_err_q, addr_err_d;

    logic          gnt_a, gnt_b;
    logic          a_in_range, b_in_range;

    // Full 32-bit compare so high address bits can never alias into the array.
    assign a_in_range = (a_addr < 32'(DEPTH));
    assign b_in_range = (b_addr < 32'(DEPTH));

    // State register and returned-read registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_SERVE;
            clr_cnt_q  <= '0;
            last_gnt_q <= LAST_B;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            last_gnt_q <= last_gnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Next state, clear sweep, arbitration and memory drive.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        last_gnt_d = last_gnt_q;
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        init_busy  = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                init_busy = 1'b1;
                mem_write = 1'b1;
                mem_addr  = 32'(clr_cnt_q);
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CW'(DEPTH - 1)) begin
                    state_d   = ST_SERVE;
                    clr_cnt_d = '0;
                end
            end
            ST_SERVE: begin
                // On a tie the port that did not win last time goes first.
                if (a_req && (!b_req || (last_gnt_q == LAST_B))) begin
                    gnt_a = 1'b1;
                end else if (b_req) begin
                    gnt_b = 1'b1;
                end

                if (gnt_a) begin
                    last_gnt_d = LAST_A;
                    mem_addr   = a_addr;
                    mem_wdata  = a_wdata;
                    mem_write  = a_we & a_in_range;
                    mem_read   = ~a_we;
                end else if (gnt_b) begin
                    last_gnt_d = LAST_B;
                    mem_addr   = b_addr;
                    mem_wdata  = b_wdata;
                    mem_write  = b_we & b_in_range;
                    mem_read   = ~b_we;
                end
            end
            default: begin
                state_d = ST_SERVE;
            end
        endcase

        // Nothing may reach the memory while reset is held.
        if (rst) begin
            gnt_a     = 1'b0;
            gnt_b     = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    // Read capture: out-of-range reads return zero, rdata holds between reads.
    always_comb begin
        a_rvalid_d = gnt_a & ~a_we;
        b_rvalid_d = gnt_b & ~b_we;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        if (a_rvalid_d) begin
            a_rdata_d = a_in_range ? mem_rdata : '0;
        end
        if (b_rvalid_d) begin
            b_rdata_d = b_in_range ? mem_rdata : '0;
        end
        addr_err_d = (gnt_a & ~a_in_range) | (gnt_b & ~b_in_range);
    end

    assign a_gnt    = gnt_a;
    assign b_gnt    = gnt_b;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign addr_err = addr_err_q;

endmodule
